// File: rtl/i2s_transceiver.sv
// I2S master transceiver: generates bclk/lrclk from clk, deserializes ADC
// data into left/right sample pairs and serializes DAC sample pairs (Philips format).
module i2s_transceiver #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SLOT_WIDTH = 32,
    parameter int unsigned BCLK_RATIO = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  bclk,
    output logic                  lrclk,
    input  logic                  adc_data,
    output logic                  dac_data,
    output logic [DATA_WIDTH-1:0] rx_left,
    output logic [DATA_WIDTH-1:0] rx_right,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_left,
    input  logic [DATA_WIDTH-1:0] tx_right,
    output logic                  tx_ready
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned S     = SLOT_WIDTH;
    localparam int unsigned R     = BCLK_RATIO;
    localparam int unsigned DIV_W = (R > 2) ? $clog2(R) : 1;
    localparam int unsigned BIT_W = $clog2(2 * S);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(R - 1);
    localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(R / 2);
    localparam logic [DIV_W-1:0] DIV_PRE    = DIV_W'(R / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(2 * S - 1);
    localparam logic [BIT_W-1:0] BIT_SLOT   = BIT_W'(S);
    localparam logic [BIT_W-1:0] BIT_DATA   = BIT_W'(W);
    localparam logic [BIT_W-1:0] LR_RISE    = BIT_W'(S - 1);
    localparam logic [BIT_W-1:0] LR_FALL    = BIT_W'(2 * S - 2);
    localparam logic [BIT_W-1:0] LEFT_LAST  = BIT_W'(W - 1);
    localparam logic [BIT_W-1:0] RIGHT_LAST = BIT_W'(S + W - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_nxt;
    logic             div_wrap;

    logic [W-1:0]     tx_hold_l;
    logic [W-1:0]     tx_hold_r;
    logic [W-1:0]     hold_l_nxt;
    logic [W-1:0]     hold_r_nxt;
    logic             tx_ch;
    logic [BIT_W-1:0] tx_pos;
    logic [W-1:0]     tx_word;
    logic [W-1:0]     tx_shifted;
    logic             dac_nxt;

    logic [W-1:0]     rx_shift;
    logic [W-1:0]     left_hold;
    logic [W-1:0]     shift_nxt;
    logic             rx_sample;
    logic [BIT_W-1:0] rx_pos;

    // Clock-divider and bit-position counters
    always_comb begin
        div_wrap = (div_cnt == DIV_LAST);
        div_nxt  = div_wrap ? '0 : div_cnt + DIV_W'(1);
        bit_nxt  = bit_cnt;
        if (div_wrap) begin
            bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        end
    end

    // Transmit bit for the upcoming counter state; a fresh pair is used in the load cycle
    always_comb begin
        hold_l_nxt = tx_ready ? tx_left  : tx_hold_l;
        hold_r_nxt = tx_ready ? tx_right : tx_hold_r;
        tx_ch      = (bit_nxt >= BIT_SLOT);
        tx_pos     = tx_ch ? bit_nxt - BIT_SLOT : bit_nxt;
        tx_word    = tx_ch ? hold_r_nxt : hold_l_nxt;
        tx_shifted = tx_word << tx_pos;
        dac_nxt    = (tx_pos < BIT_DATA) && tx_shifted[W-1];
    end

    // Receive sampling on the bclk rising edge
    always_comb begin
        rx_sample = (div_cnt == DIV_PRE);
        rx_pos    = (bit_cnt >= BIT_SLOT) ? bit_cnt - BIT_SLOT : bit_cnt;
        shift_nxt = W'({rx_shift, adc_data});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            bit_cnt   <= '0;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            dac_data  <= 1'b0;
            tx_ready  <= 1'b0;
            tx_hold_l <= '0;
            tx_hold_r <= '0;
            rx_shift  <= '0;
            left_hold <= '0;
            rx_left   <= '0;
            rx_right  <= '0;
            rx_valid  <= 1'b0;
        end else begin
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            bclk      <= (div_nxt >= DIV_HALF);
            lrclk     <= (bit_nxt >= LR_RISE) && (bit_nxt <= LR_FALL);
            tx_ready  <= (div_nxt == DIV_LAST) && (bit_nxt == BIT_LAST);
            dac_data  <= dac_nxt;
            tx_hold_l <= hold_l_nxt;
            tx_hold_r <= hold_r_nxt;
            rx_valid  <= 1'b0;
            if (rx_sample && (rx_pos < BIT_DATA)) begin
                rx_shift <= shift_nxt;
                if (bit_cnt == LEFT_LAST) begin
                    left_hold <= shift_nxt;
                end
                if (bit_cnt == RIGHT_LAST) begin
                    rx_left  <= left_hold;
                    rx_right <= shift_nxt;
                    rx_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_transceiver.sv
// Bench for i2s_transceiver: default instance (BFM codec / loopback) plus a
// 24-bit, R=2 loopback instance, with a received-pair scoreboard per instance.
module tb_i2s_transceiver;

    localparam int S  = 32;
    localparam int W0 = 16;
    localparam int R0 = 4;
    localparam int W1 = 24;
    localparam int R1 = 2;

    typedef struct {
        int          t;
        logic [23:0] l;
        logic [23:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic mode;
    logic [15:0] bfm_left, bfm_right;
    logic bfm_bit;
    int   cyc;

    logic        bclk0, lrclk0, adc0, dac0, rx_valid0, tx_ready0;
    logic [15:0] rx_left0, rx_right0, tx_left0, tx_right0;
    logic        bclk1, lrclk1, adc1, dac1, rx_valid1, tx_ready1;
    logic [23:0] rx_left1, rx_right1, tx_left1, tx_right1;

    logic [23:0] m0_l, m0_r, m1_l, m1_r;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Serial bit carried in cycle t for a left/right pair (Philips I2S, S-bit slots)
    function automatic logic exp_bit(input int t, input int r, input int w,
                                     input logic [23:0] l, input logic [23:0] rr);
        int b, p;
        logic [23:0] word;
        b = (t / r) % (2 * S);
        p = b % S;
        word = (b < S) ? l : rr;
        if (p >= w) return 1'b0;
        return word[w-1-p];
    endfunction

    assign bfm_bit = exp_bit(cyc, R0, W0, {8'h0, bfm_left}, {8'h0, bfm_right});
    assign adc0 = mode ? dac0 : bfm_bit;
    assign adc1 = dac1;

    i2s_transceiver dut0 (
        .clk(clk), .rst_n(rst_n), .bclk(bclk0), .lrclk(lrclk0),
        .adc_data(adc0), .dac_data(dac0), .rx_left(rx_left0), .rx_right(rx_right0),
        .rx_valid(rx_valid0), .tx_left(tx_left0), .tx_right(tx_right0), .tx_ready(tx_ready0)
    );

    i2s_transceiver #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .BCLK_RATIO(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .bclk(bclk1), .lrclk(lrclk1),
        .adc_data(adc1), .dac_data(dac1), .rx_left(rx_left1), .rx_right(rx_right1),
        .rx_valid(rx_valid1), .tx_left(tx_left1), .tx_right(tx_right1), .tx_ready(tx_ready1)
    );

    task automatic check(input string tag, input int t, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // Received pairs: compare against the scoreboard head
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rx_valid0 === 1'b1) begin
            if (q0.size() == 0) check("rx0_spurious", cyc, 64'(rx_valid0), 64'(0));
            else begin
                e0 = q0.pop_front();
                check("rx0_time",  cyc, 64'(cyc), 64'(e0.t));
                check("rx0_left",  cyc, 64'(rx_left0), 64'(e0.l));
                check("rx0_right", cyc, 64'(rx_right0), 64'(e0.r));
            end
        end
        if (rst_n === 1'b1 && rx_valid1 === 1'b1) begin
            if (q1.size() == 0) check("rx1_spurious", cyc, 64'(rx_valid1), 64'(0));
            else begin
                e1 = q1.pop_front();
                check("rx1_time",  cyc, 64'(cyc), 64'(e1.t));
                check("rx1_left",  cyc, 64'(rx_left1), 64'(e1.l));
                check("rx1_right", cyc, 64'(rx_right1), 64'(e1.r));
            end
        end
    end

    task automatic check_cycle(input int t);
        int b0, b1;
        logic [3:0] x0, x1;
        b0 = (t / R0) % (2 * S);
        b1 = (t / R1) % (2 * S);
        x0 = {(t % R0) >= R0 / 2, (b0 >= S - 1) && (b0 <= 2 * S - 2),
              exp_bit(t, R0, W0, m0_l, m0_r), (t % (2 * S * R0)) == 2 * S * R0 - 1};
        x1 = {(t % R1) >= R1 / 2, (b1 >= S - 1) && (b1 <= 2 * S - 2),
              exp_bit(t, R1, W1, m1_l, m1_r), (t % (2 * S * R1)) == 2 * S * R1 - 1};
        check("dut0_pins", t, 64'({bclk0, lrclk0, dac0, tx_ready0}), 64'(x0));
        check("dut1_pins", t, 64'({bclk1, lrclk1, dac1, tx_ready1}), 64'(x1));
        if (x0[0]) begin m0_l = {8'h0, tx_left0}; m0_r = {8'h0, tx_right0}; end
        if (x1[0]) begin m1_l = tx_left1; m1_r = tx_right1; end
    endtask

    task automatic run(input int t0, input int t1);
        for (int t = t0; t < t1; t++) begin
            @(negedge clk);
            check_cycle(t);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dut0"}, cyc, 64'({bclk0, lrclk0, dac0, rx_valid0, tx_ready0, rx_left0, rx_right0}), 64'(0));
        check({tag, "_dut1"}, cyc, 64'({bclk1, lrclk1, dac1, rx_valid1, tx_ready1, rx_left1, rx_right1}), 64'(0));
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        m0_l = '0; m0_r = '0; m1_l = '0; m1_r = '0;
    endtask

    // Wide instance runs loopback continuously; first frame returns zeros
    task automatic expect1_frames(input int n);
        int t;
        for (int k = 0; ; k++) begin
            t = (S + W1 - 1) * R1 + R1 / 2 + k * 2 * S * R1;
            if (t >= n) break;
            q1.push_back('{t, (k == 0) ? 24'h0 : 24'h800001, (k == 0) ? 24'h0 : 24'h7FFFFE});
        end
    endtask

    task automatic end_session(input string tag);
        check({tag, "_q0_pending"}, cyc, 64'(q0.size()), 64'(0));
        check({tag, "_q1_pending"}, cyc, 64'(q1.size()), 64'(0));
        q0.delete();
        q1.delete();
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        bfm_left  = 16'h8000;
        bfm_right = 16'h7FFF;
        tx_left0  = 16'hA5C3;
        tx_right0 = 16'h0F0F;
        tx_left1  = 24'h800001;
        tx_right1 = 24'h7FFFFE;
        m0_l = '0; m0_r = '0; m1_l = '0; m1_r = '0;

        // Session 1: BFM codec on the default instance, idle pin pattern
        repeat (2) begin @(negedge clk); check_reset_state("rst_init"); end
        release_reset();
        q0.push_back('{190, 24'h8000, 24'h7FFF});
        expect1_frames(256);
        run(0, 256);
        end_session("s1");

        // Session 2: loopback, left input disturbed outside the capture cycle
        rst_n = 1'b0;
        mode  = 1'b1;
        @(negedge clk);
        check_reset_state("rst_s2");
        release_reset();
        q0.push_back('{190, 24'h0, 24'h0});
        q0.push_back('{446, 24'hA5C3, 24'h0F0F});
        q0.push_back('{702, 24'hA5C3, 24'h0F0F});
        expect1_frames(720);
        run(0, 301);
        tx_left0 = 16'hFFFF;
        run(301, 401);
        tx_left0 = 16'hA5C3;
        run(401, 720);
        end_session("s2");

        // Session 3: reset asserted mid-frame at t=170 for 3 cycles
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("rst_s3");
        release_reset();
        expect1_frames(171);
        run(0, 171);
        rst_n = 1'b0;
        repeat (3) begin @(negedge clk); check_reset_state("rst_mid"); end
        end_session("s3a");
        release_reset();
        q0.push_back('{190, 24'h0, 24'h0});
        expect1_frames(260);
        run(0, 260);
        end_session("s3b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
